dpt_pulse_gen: RTL and testbench
================================

# dpt_pulse_gen

Double-pulse gate sequencer sitting directly downstream of the bus-voltage window classifier. It consumes the classifier's registered enable and the board's over-temperature input, and drives the two gate outputs K1/K2 of one leg with a single double-pulse shot per enable assertion. Each shot is a first pulse, a gap, then a second pulse. K2 is driven complementary to K1 during the gap, with dead time. The block aborts cleanly on over-temperature or loss of enable.

## Interface
- `T1`, 8000: K1 first-pulse width, clk cycles (200 µs at 40 MHz).
- `T_OFF`, 400: K1 off gap between the pulses, cycles.
- `T2`, 400: K1 second-pulse width, cycles.
- `DEAD`, 40: dead time between K1 and K2 edges, cycles.
- `ARM_CYC`, 4000: cycles enable must stay high before the shot starts.
- `REARM`, 40000: hold-off after a shot or abort before returning to IDLE, cycles.
- `CNT_W`, 16: width of the shared down-counter.
- `clk`  in  1  system clock (40 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  classifier enable; synchronous to clk.
- `TEM`  in  1  over-temperature fault, active-high; asynchronous.
- `K1`  out  1  upper/test gate drive, active-high, registered.
- `K2`  out  1  complementary gate drive, active-high, registered.
- `busy`  out  1  high in any state other than IDLE.
- `fault`  out  1  high while in ABORT; cleared on leaving ABORT.

## Operation
- TEM passes through a 2-flop synchronizer to give `tem_s`. `enable` is used directly.
- States and transitions:
  - IDLE: go to ARM when `enable` is high and `tem_s` is low.
  - ARM: counts `ARM_CYC`. If `enable` is low, return to IDLE without a fault. If `tem_s` is high, go to ABORT. Otherwise go to P1.
  - P1: K1=1 for `T1` cycles.
  - GAP: K1=0 for `T_OFF` cycles. K2=1 from gap cycle `DEAD` through gap cycle `T_OFF-DEAD-1` (0-based).
  - P2: K1=1 for `T2` cycles.
  - HOLD: counts `REARM` with K1=K2=0, then waits for `enable`=0 before going to IDLE. This gives one shot per enable assertion.
  - ABORT: K1=K2=0 and fault=1. Waits until `enable`=0, `tem_s`=0 and `REARM` cycles have elapsed, then goes to IDLE.
- In P1, GAP or P2, `tem_s`=1 or `enable`=0 forces ABORT. K1 and K2 register 0 on the next edge.
- A single `CNT_W`-bit down-counter is loaded with the (duration − 1) of the entered state. The state advances when the counter reaches 0.
- Parameter legality, checked at elaboration (fatal if violated): `T1`, `T2`, `T_OFF` ≥ 1; `T_OFF` ≥ 2·`DEAD`+1; every duration < 2^`CNT_W`.
- K1 and K2 are never high in the same cycle. This invariant holds by construction and is asserted.

## Timing
- Reset values: K1=0, K2=0, busy=0, fault=0, state=IDLE, counter=0, synchronizer flops=0.
- `enable` sampled high at edge E: busy=1 from E+1, and K1 rises at edge E+1+`ARM_CYC`.
- K1 is high for exactly `T1` cycles, low for `T_OFF`, high for `T2`.
- K2 rises `DEAD` cycles after K1 falls and falls `DEAD` cycles before K1 rises again.
- TEM rising edge to K1/K2 low: at most 3 clk edges (2 synchronizer + 1 output register).
- `enable` falling to K1/K2 low: 1 edge.
- Simultaneous state-duration expiry and abort condition: abort wins.
- If `rst` is asserted mid-pulse, K1 and K2 go low asynchronously and immediately.

## Configuration
- `DPT_SHOT_COUNT_EN`:
  - Defined: adds output `shot_cnt` (out, 16 bits). It increments, saturating at 16'hFFFF, on each completed P2→HOLD transition; aborted shots are not counted. It resets to 0.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `dpt_pkg`:
  - state enum `dpt_state_t` (IDLE, ARM, P1, GAP, P2, HOLD, ABORT);
  - default timing constants;
  - `DPT_SHOT_W` = 16.
- Sub-module `dpt_sync2`: generic 2-flop synchronizer with async active-high reset, used for TEM.
- The FSM, counter and output registers stay in `dpt_pulse_gen`.

## Test plan
Sim parameters: `T1`=20, `T_OFF`=10, `T2`=5, `DEAD`=2, `ARM_CYC`=4, `REARM`=8.
- Enable held high from cycle 0 → K1 high for cycles 5–24 and 35–39; K2 high for cycles 27–32; exactly one shot, busy until `enable` drops.
- TEM rises at cycle 30 (during GAP) → K2 low by cycle 33, fault=1, no second pulse; with `enable` and TEM low, IDLE after 8 hold-off cycles.
- Enable drops at cycle 3 (during ARM) → no K1 pulse, fault stays 0, IDLE next cycle.
- Enable drops and is reasserted right after HOLD → second full shot with identical timing; with `DPT_SHOT_COUNT_EN` defined, `shot_cnt` reads 2.
- `rst` pulsed at cycle 12 (mid-P1) → K1 low immediately, state IDLE, no fault.
- Every scenario: assertion that K1 & K2 is never 1 passes.

Source files
------------

// File: rtl/dpt_pkg.sv
// rtl/dpt_pkg.sv - double-pulse sequencer states, default timing and shot counter width
package dpt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    P1    = 3'd2,
    GAP   = 3'd3,
    P2    = 3'd4,
    HOLD  = 3'd5,
    ABORT = 3'd6
  } dpt_state_t;

  // Defaults are clk cycles at 40 MHz.
  localparam int DPT_T1_DEF      = 8000;
  localparam int DPT_T_OFF_DEF   = 400;
  localparam int DPT_T2_DEF      = 400;
  localparam int DPT_DEAD_DEF    = 40;
  localparam int DPT_ARM_CYC_DEF = 4000;
  localparam int DPT_REARM_DEF   = 40000;
  localparam int DPT_CNT_W_DEF   = 16;

  localparam int DPT_SHOT_W = 16;

endpackage

// File: rtl/dpt_pulse_gen_if.sv
// rtl/dpt_pulse_gen_if.sv - enable/TEM inputs and gate/status outputs; DPT_SHOT_COUNT_EN adds shot_cnt
interface dpt_pulse_gen_if;

  logic enable;
  logic TEM;
  logic K1;
  logic K2;
  logic busy;
  logic fault;
`ifdef DPT_SHOT_COUNT_EN
  logic [dpt_pkg::DPT_SHOT_W-1:0] shot_cnt;

  modport master (output enable, TEM, input K1, K2, busy, fault, shot_cnt);
  modport slave  (input enable, TEM, output K1, K2, busy, fault, shot_cnt);
`else
  modport master (output enable, TEM, input K1, K2, busy, fault);
  modport slave  (input enable, TEM, output K1, K2, busy, fault);
`endif

endinterface

// File: rtl/dpt_sync2.sv
// rtl/dpt_sync2.sv - two-flop synchronizer, asynchronous active-high reset to 0
module dpt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dpt_pulse_gen.sv
// rtl/dpt_pulse_gen.sv - one double-pulse shot on K1 per enable assertion, complementary K2 in the gap
// Optional shot counter output enabled by DPT_SHOT_COUNT_EN.
module dpt_pulse_gen
  import dpt_pkg::*;
#(
  parameter int T1      = DPT_T1_DEF,
  parameter int T_OFF   = DPT_T_OFF_DEF,
  parameter int T2      = DPT_T2_DEF,
  parameter int DEAD    = DPT_DEAD_DEF,
  parameter int ARM_CYC = DPT_ARM_CYC_DEF,
  parameter int REARM   = DPT_REARM_DEF,
  parameter int CNT_W   = DPT_CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  dpt_pulse_gen_if.slave  bus
);

  if (T1 < 1 || T2 < 1 || T_OFF < 1) begin : g_bad_dur
    $fatal(1, "dpt_pulse_gen: T1, T2 and T_OFF must be at least 1");
  end
  if (T_OFF < 2 * DEAD + 1) begin : g_bad_dead
    $fatal(1, "dpt_pulse_gen: T_OFF must be at least 2*DEAD+1");
  end
  if ((T1 >> CNT_W) != 0 || (T_OFF >> CNT_W) != 0 || (T2 >> CNT_W) != 0 ||
      (ARM_CYC >> CNT_W) != 0 || (REARM >> CNT_W) != 0) begin : g_bad_width
    $fatal(1, "dpt_pulse_gen: every duration must fit in CNT_W bits");
  end

  localparam int ARM_M1   = (ARM_CYC > 0) ? ARM_CYC - 1 : 0;
  localparam int REARM_M1 = (REARM > 0) ? REARM - 1 : 0;

  localparam logic [CNT_W-1:0] L_ARM   = CNT_W'(ARM_M1);
  localparam logic [CNT_W-1:0] L_T1    = CNT_W'(T1 - 1);
  localparam logic [CNT_W-1:0] L_TOFF  = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] L_T2    = CNT_W'(T2 - 1);
  localparam logic [CNT_W-1:0] L_REARM = CNT_W'(REARM_M1);
  // Gap counts down, so gap cycle i holds T_OFF-1-i: the K2 window is symmetric.
  localparam logic [CNT_W-1:0] K2_LO   = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] K2_HI   = CNT_W'(T_OFF - 1 - DEAD);

  logic             tem_s;
  dpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             k1_q, k1_d;
  logic             k2_q, k2_d;
  logic             abort_c;
  logic             cnt_zero;

  dpt_sync2 u_tem_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.TEM),
    .q   (tem_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_c  = tem_s || !bus.enable;
    cnt_zero = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (bus.enable && !tem_s) begin
          state_d = ARM;
          cnt_d   = L_ARM;
        end
      end
      ARM: begin
        if (!bus.enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tem_s) begin
          state_d = ABORT;
          cnt_d   = L_REARM;
        end else if (cnt_zero) begin
          state_d = P1;
          cnt_d   = L_T1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      P1, GAP, P2: begin
        // Abort is tested before expiry so it wins on the same edge.
        if (abort_c) begin
          state_d = ABORT;
          cnt_d   = L_REARM;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == P1) begin
          state_d = GAP;
          cnt_d   = L_TOFF;
        end else if (state_q == GAP) begin
          state_d = P2;
          cnt_d   = L_T2;
        end else begin
          state_d = HOLD;
          cnt_d   = L_REARM;
        end
      end
      HOLD: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!bus.enable) begin
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!bus.enable && !tem_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    k1_d = (state_d == P1) || (state_d == P2);
    k2_d = (state_d == GAP) && (cnt_d >= K2_LO) && (cnt_d <= K2_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
    end
  end

`ifdef DPT_SHOT_COUNT_EN
  logic [DPT_SHOT_W-1:0] shot_q, shot_d;

  always_comb begin
    shot_d = shot_q;
    if (state_q == P2 && state_d == HOLD && shot_q != '1) begin
      shot_d = shot_q + DPT_SHOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_q <= '0;
    end else begin
      shot_q <= shot_d;
    end
  end

  assign bus.shot_cnt = shot_q;
`endif

  assign bus.K1    = k1_q;
  assign bus.K2    = k2_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.fault = (state_q == ABORT);

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(k1_q && k2_q));

endmodule

// File: tb/tb_dpt_pulse_gen.sv
// tb/tb_dpt_pulse_gen.sv - table-driven check of shot timing, aborts, reset and optional shot count
module tb_dpt_pulse_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  dpt_pulse_gen_if bus ();

  dpt_pulse_gen #(
    .T1      (20),
    .T_OFF   (10),
    .T2      (5),
    .DEAD    (2),
    .ARM_CYC (4),
    .REARM   (8),
    .CNT_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit do_rst;
    int n;
    bit en;
    bit tem;
    bit k1;
    bit k2;
    bit busy;
    bit fault;
    int shots;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input int n, input bit en, input bit tem,
                     input bit k1, input bit k2, input bit b, input bit f, input int s);
    vec_t v;
    v.do_rst = r; v.n = n; v.en = en; v.tem = tem;
    v.k1 = k1; v.k2 = k2; v.busy = b; v.fault = f; v.shots = s;
    tbl.push_back(v);
  endtask

  // ARM through P2 with enable held high; shots is the count during the shot.
  task automatic add_shot(input bit r, input int s);
    add(r,  4, 1, 0, 0, 0, 1, 0, s);
    add(0, 20, 1, 0, 1, 0, 1, 0, s);
    add(0,  2, 1, 0, 0, 0, 1, 0, s);
    add(0,  6, 1, 0, 0, 1, 1, 0, s);
    add(0,  2, 1, 0, 0, 0, 1, 0, s);
    add(0,  5, 1, 0, 1, 0, 1, 0, s);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input bit k1, input bit k2, input bit b, input bit f, input int s);
    chk("K1",    16'(bus.K1),    16'(k1));
    chk("K2",    16'(bus.K2),    16'(k2));
    chk("busy",  16'(bus.busy),  16'(b));
    chk("fault", 16'(bus.fault), 16'(f));
`ifdef DPT_SHOT_COUNT_EN
    chk("shot_cnt", bus.shot_cnt, 16'(s));
`else
    if (s < 0) chk("shot_cnt_arg", 16'(s), 16'd0);
`endif
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    bus.TEM    = 1'b0;
    rst        = 1'b1;
    #1;
    cyc = 0;
    chk_out(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.K1 && bus.K2) begin
        errors++;
        $display("FAIL k1_k2_overlap cycle %0d: K1=%0b K2=%0b expected not both 1", cyc, bus.K1, bus.K2);
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.TEM    = 1'b0;

    // Single shot with enable held: K1 5-24 and 35-39, K2 27-32, busy until enable drops.
    add_shot(1, 0);
    add(0, 16, 1, 0, 0, 0, 1, 0, 1);
    add(0,  3, 0, 0, 0, 0, 0, 0, 1);

    // TEM rises after cycle 30: K2 still high 31-32, ABORT from 33, IDLE at 41.
    add(1,  4, 1, 0, 0, 0, 1, 0, 0);
    add(0, 20, 1, 0, 1, 0, 1, 0, 0);
    add(0,  2, 1, 0, 0, 0, 1, 0, 0);
    add(0,  4, 1, 0, 0, 1, 1, 0, 0);
    add(0,  2, 1, 1, 0, 1, 1, 0, 0);
    add(0,  1, 1, 1, 0, 0, 1, 1, 0);
    add(0,  7, 0, 0, 0, 0, 1, 1, 0);
    add(0,  3, 0, 0, 0, 0, 0, 0, 0);

    // Enable drops after cycle 3 in ARM: IDLE at cycle 4, never a pulse.
    add(1,  3, 1, 0, 0, 0, 1, 0, 0);
    add(0,  6, 0, 0, 0, 0, 0, 0, 0);

    // Enable dropped at end of HOLD and reasserted: identical second shot.
    add_shot(1, 0);
    add(0,  8, 1, 0, 0, 0, 1, 0, 1);
    add(0,  1, 0, 0, 0, 0, 0, 0, 1);
    add_shot(0, 1);
    add(0,  8, 1, 0, 0, 0, 1, 0, 2);
    add(0,  2, 0, 0, 0, 0, 0, 0, 2);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      bus.enable = tbl[i].en;
      bus.TEM    = tbl[i].tem;
      for (int c = 0; c < tbl[i].n; c++) begin
        step(1);
        chk_out(tbl[i].k1, tbl[i].k2, tbl[i].busy, tbl[i].fault, tbl[i].shots);
      end
    end

    // rst pulsed mid-P1: K1 drops without waiting for a clock edge.
    do_reset();
    bus.enable = 1'b1;
    step(12);
    chk("rst_mid_p1_k1_before", 16'(bus.K1), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_p1_k1", 16'(bus.K1), 16'd0);
    chk("rst_mid_p1_busy", 16'(bus.busy), 16'd0);
    chk("rst_mid_p1_fault", 16'(bus.fault), 16'd0);
    bus.enable = 1'b0;
    rst = 1'b0;
    step(1);
    chk_out(0, 0, 0, 0, 0);

    // Enable loss mid-P1: K1 low one edge later, fault for the REARM hold-off.
    do_reset();
    bus.enable = 1'b1;
    step(10);
    chk("en_loss_k1_before", 16'(bus.K1), 16'd1);
    bus.enable = 1'b0;
    step(1);
    chk_out(0, 0, 1, 1, 0);
    step(7);
    chk_out(0, 0, 1, 1, 0);
    step(1);
    chk_out(0, 0, 0, 0, 0);

    // Over-temperature already present in IDLE blocks a new shot.
    do_reset();
    bus.TEM = 1'b1;
    step(3);
    bus.enable = 1'b1;
    step(3);
    chk_out(0, 0, 0, 0, 0);
    bus.TEM = 1'b0;
    step(3);
    chk("tem_clear_arms", 16'(bus.busy), 16'd1);

    bus.enable = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
